// File: rtl/ioshim_mem_mp_pkg.sv
// Shared types for the I/O-shim multi-port memory: clear-sequencer states and
// collision-mode encodings.
package ioshim_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Port-2 / port-1 result when a read address matches an accepted port-1 write
    localparam bit WT_READ_FIRST = 1'b0;
    localparam bit WT_NEW_DATA   = 1'b1;

endpackage

// File: rtl/ioshim_mem_mp_if.sv
// Bus bundle between the shim master / peripheral readers and the memory.
interface ioshim_mem_mp_if
#(
    parameter int NBYTES = 2,
    parameter int AW     = 11,
    parameter int NRD    = 1
);
    import ioshim_pkg::*;

    localparam int W = 8 * NBYTES;

    // No backpressure anywhere: a write or ren2 request is taken in the cycle it is
    // presented unless busy is high, and rvalid2[i] pulses once per taken ren2[i].
    logic [NBYTES-1:0]  wen1;
    logic [AW-1:0]      addr1;
    logic [W-1:0]       wdata1;
    logic [W-1:0]       rdata1;
    logic [NRD-1:0]     ren2;
    logic [NRD*AW-1:0]  addr2;
    logic [NRD*W-1:0]   rdata2;
    logic [NRD-1:0]     rvalid2;
    logic               clear_req;
    logic               busy;
    clr_state_e         clr_state;

    modport master (
        output wen1, addr1, wdata1, ren2, addr2, clear_req,
        input  rdata1, rdata2, rvalid2, busy, clr_state
    );

    modport slave (
        input  wen1, addr1, wdata1, ren2, addr2, clear_req,
        output rdata1, rdata2, rvalid2, busy, clr_state
    );

endinterface

// File: rtl/ioshim_mem_mp_clr.sv
// Clear sequencer: walks every word address once, emitting a zero-write strobe,
// and holds busy high for exactly MEMSIZE cycles.
module ioshim_mem_clr
    import ioshim_pkg::*;
#(
    parameter int MEMSIZE      = 128,
    parameter int CW           = 7,
    parameter bit CLR_ON_RESET = 1'b0
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear_req_i,
    output logic          busy_o,
    output logic          clr_we_o,
    output logic [CW-1:0] clr_addr_o,
    output clr_state_e    state_o
);

    localparam logic [CW-1:0] LAST = CW'(MEMSIZE - 1);

    clr_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= CLR_ON_RESET ? CLEAR : IDLE;
            cnt_q   <= '0;
            busy_q  <= CLR_ON_RESET;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear_req_i) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt_q == LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign clr_we_o   = busy_q;
    assign clr_addr_o = cnt_q;
    assign state_o    = state_q;

endmodule

// File: rtl/ioshim_mem_mp.sv
// Multi-port shim memory: byte-masked read/write port 1, NRD read-only channels on
// port 2, selectable collision bypass, optional output register and clear sequencer.
module ioshim_mem_mp
    import ioshim_pkg::*;
#(
    parameter int NBYTES        = 2,
    parameter int MEMSIZE       = 128,
    parameter int AW            = 11,
    parameter int NRD           = 1,
    parameter bit OUTREG        = 1'b0,
    parameter bit WRITE_THROUGH = 1'b0,
    parameter bit CLR_ON_RESET  = 1'b0
) (
    input logic           clk,
    input logic           resetn,
    ioshim_mem_mp_if.slave bus
);

    localparam int W    = 8 * NBYTES;
    localparam int IW   = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
    localparam bit MODE = WRITE_THROUGH ? WT_NEW_DATA : WT_READ_FIRST;

    logic [W-1:0]      mem_q [MEMSIZE];
    logic              busy;
    logic              clr_we;
    logic [IW-1:0]     clr_addr;
    clr_state_e        clr_state;
    logic [NBYTES-1:0] user_be;
    logic [W-1:0]      rd1_d, rd1_q;
    logic [NRD*W-1:0]  rd2_d, rd2_q;
    logic [NRD-1:0]    vld_q;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(MEMSIZE);
    endfunction

    // Out-of-range reads see zero; in write-through mode accepted bytes bypass the array.
    function automatic logic [W-1:0] read_word(input logic [W-1:0] stored,
                                               input logic [AW-1:0] a,
                                               input logic [AW-1:0] wa,
                                               input logic [NBYTES-1:0] be,
                                               input logic [W-1:0] wd);
        logic [W-1:0] w;
        w = stored;
        if (MODE == WT_NEW_DATA && a == wa) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
            end
        end
        if (!in_range(a)) w = '0;
        return w;
    endfunction

    ioshim_mem_clr #(
        .MEMSIZE      (MEMSIZE),
        .CW           (IW),
        .CLR_ON_RESET (CLR_ON_RESET)
    ) u_clr (
        .clk         (clk),
        .resetn      (resetn),
        .clear_req_i (bus.clear_req),
        .busy_o      (busy),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr),
        .state_o     (clr_state)
    );

    assign bus.busy      = busy;
    assign bus.clr_state = clr_state;

    assign user_be = (!busy && in_range(bus.addr1)) ? bus.wen1 : '0;

    // Reset never touches the array; the clear sequencer owns it while busy.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (clr_we) begin
                mem_q[clr_addr] <= '0;
            end else begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (user_be[b]) mem_q[bus.addr1[IW-1:0]][b*8 +: 8] <= bus.wdata1[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rd1_d = read_word(mem_q[bus.addr1[IW-1:0]], bus.addr1, bus.addr1, user_be, bus.wdata1);
        rd2_d = '0;
        for (int i = 0; i < NRD; i++) begin
            rd2_d[i*W +: W] = read_word(mem_q[bus.addr2[i*AW +: IW]], bus.addr2[i*AW +: AW],
                                        bus.addr1, user_be, bus.wdata1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd1_q <= '0;
            rd2_q <= '0;
            vld_q <= '0;
        end else begin
            if (!busy) rd1_q <= rd1_d;
            for (int i = 0; i < NRD; i++) begin
                if (bus.ren2[i] && !busy) rd2_q[i*W +: W] <= rd2_d[i*W +: W];
            end
            vld_q <= bus.ren2 & {NRD{!busy}};
        end
    end

    // The second stage copies unconditionally so reads taken before busy still drain.
    if (OUTREG) begin : g_outreg
        logic [W-1:0]     out1_q;
        logic [NRD*W-1:0] out2_q;
        logic [NRD-1:0]   vld2_q;

        always_ff @(posedge clk) begin
            if (!resetn) begin
                out1_q <= '0;
                out2_q <= '0;
                vld2_q <= '0;
            end else begin
                out1_q <= rd1_q;
                for (int i = 0; i < NRD; i++) begin
                    if (vld_q[i]) out2_q[i*W +: W] <= rd2_q[i*W +: W];
                end
                vld2_q <= vld_q;
            end
        end

        assign bus.rdata1  = out1_q;
        assign bus.rdata2  = out2_q;
        assign bus.rvalid2 = vld2_q;
    end else begin : g_direct
        assign bus.rdata1  = rd1_q;
        assign bus.rdata2  = rd2_q;
        assign bus.rvalid2 = vld_q;
    end

endmodule

// File: tb/tb_ioshim_mem_mp.sv
// Bench for ioshim_mem_mp: two configurations driven from one stimulus stream and
// checked against a word-array reference model.
module tb_ioshim_mem_mp;
    import ioshim_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [1:0]  wen1;
    logic [10:0] addr1;
    logic [15:0] wdata1;
    logic [2:0]  ren2;
    logic [10:0] addr2 [3];
    logic        clear_req;

    int total = 0;
    int bad   = 0;

    // A: NRD=3, latency 2, read-first, clear on reset.  B: NRD=1, latency 1, write-through.
    ioshim_mem_mp_if #(.NBYTES(2), .AW(11), .NRD(3)) if_a ();
    ioshim_mem_mp_if #(.NBYTES(2), .AW(11), .NRD(1)) if_b ();

    assign if_a.wen1 = wen1;  assign if_a.addr1 = addr1;  assign if_a.wdata1 = wdata1;
    assign if_a.ren2 = ren2;  assign if_a.addr2 = {addr2[2], addr2[1], addr2[0]};
    assign if_a.clear_req = clear_req;
    assign if_b.wen1 = wen1;  assign if_b.addr1 = addr1;  assign if_b.wdata1 = wdata1;
    assign if_b.ren2 = ren2[0];  assign if_b.addr2 = addr2[0];
    assign if_b.clear_req = clear_req;

    ioshim_mem_mp #(.NBYTES(2), .MEMSIZE(128), .AW(11), .NRD(3), .OUTREG(1'b1),
                    .WRITE_THROUGH(1'b0), .CLR_ON_RESET(1'b1))
        dut_a (.clk(clk), .resetn(resetn), .bus(if_a));
    ioshim_mem_mp #(.NBYTES(2), .MEMSIZE(128), .AW(11), .NRD(1), .OUTREG(1'b0),
                    .WRITE_THROUGH(1'b1), .CLR_ON_RESET(1'b0))
        dut_b (.clk(clk), .resetn(resetn), .bus(if_b));

    // Reference model: index 0 = A, 1 = B
    logic [15:0] mm [2][128];
    int          left_m [2];
    logic [15:0] e1 [2];
    logic [15:0] e2 [2][3];
    logic [2:0]  ev [2];
    logic        eb [2];
    logic [15:0] s1;
    logic [15:0] s2 [3];
    logic [2:0]  sv;

    function automatic logic [15:0] m_read(int k, logic [10:0] a);
        logic [15:0] r;
        r = 16'h0000;
        if (a < 11'd128) begin
            r = mm[k][a[6:0]];
            if (k == 1 && a == addr1 && left_m[1] == 0 && addr1 < 11'd128)
                for (int b = 0; b < 2; b++) if (wen1[b]) r[b*8 +: 8] = wdata1[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic step();
        logic [15:0] n1;
        logic [15:0] n2 [3];
        logic [2:0]  acc;
        logic        bsy;
        for (int k = 0; k < 2; k++) begin
            if (!resetn) begin
                left_m[k] = (k == 0) ? 128 : 0;
                e1[k] = '0; ev[k] = '0;
                for (int c = 0; c < 3; c++) e2[k][c] = '0;
                if (k == 0) begin
                    s1 = '0; sv = '0;
                    for (int c = 0; c < 3; c++) s2[c] = '0;
                end
            end else begin
                bsy = left_m[k] > 0;
                n1  = m_read(k, addr1);
                acc = '0;
                for (int c = 0; c < 3; c++) begin
                    n2[c]  = m_read(k, addr2[c]);
                    acc[c] = ren2[c] && !bsy && (k == 0 || c == 0);
                end
                if (k == 0) begin
                    e1[0] = s1;
                    for (int c = 0; c < 3; c++) if (sv[c]) e2[0][c] = s2[c];
                    ev[0] = sv;
                    if (!bsy) s1 = n1;
                    for (int c = 0; c < 3; c++) if (acc[c]) s2[c] = n2[c];
                    sv = acc;
                end else begin
                    if (!bsy) e1[1] = n1;
                    if (acc[0]) e2[1][0] = n2[0];
                    ev[1] = acc;
                end
                if (bsy) begin
                    mm[k][128 - left_m[k]] = 16'h0000;
                    left_m[k]--;
                end else begin
                    if (addr1 < 11'd128)
                        for (int b = 0; b < 2; b++)
                            if (wen1[b]) mm[k][addr1[6:0]][b*8 +: 8] = wdata1[b*8 +: 8];
                    if (clear_req) left_m[k] = 128;
                end
            end
            eb[k] = left_m[k] > 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen1 = '0; addr1 = '0; wdata1 = '0; ren2 = '0; clear_req = 1'b0;
        for (int c = 0; c < 3; c++) addr2[c] = '0;
    endtask

    task automatic test_reset();
        int n;
        resetn = 1'b0;
        idle();
        repeat (3) step();
        total++; if (if_a.busy !== 1'b1) begin bad++; $display("FAIL reset_busy_a: got %b want 1", if_a.busy); end
        total++; if (if_a.clr_state !== CLEAR) begin bad++; $display("FAIL reset_state_a: got %0d want CLEAR", if_a.clr_state); end
        total++; if ({if_a.rdata1, if_a.rdata2, if_a.rvalid2} !== 67'h0) begin bad++; $display("FAIL reset_out_a: got %h want 0", {if_a.rdata1, if_a.rdata2, if_a.rvalid2}); end
        total++; if (if_b.busy !== 1'b0) begin bad++; $display("FAIL reset_busy_b: got %b want 0", if_b.busy); end
        total++; if ({if_b.rdata1, if_b.rdata2, if_b.rvalid2} !== 33'h0) begin bad++; $display("FAIL reset_out_b: got %h want 0", {if_b.rdata1, if_b.rdata2, if_b.rvalid2}); end
        resetn = 1'b1;
        n = 0;
        while (n < 300) begin
            step(); n++;
            if (if_a.busy !== 1'b1) break;
        end
        total++; if (n !== 128) begin bad++; $display("FAIL auto_clear_len: got %0d want 128", n); end
        total++; if (if_a.clr_state !== IDLE) begin bad++; $display("FAIL auto_clear_state: got %0d want IDLE", if_a.clr_state); end
    endtask

    task automatic test_clear();
        int n, seen;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        total++; if ({if_a.busy, if_b.busy} !== 2'b11) begin bad++; $display("FAIL clear_start: got %b want 11", {if_a.busy, if_b.busy}); end
        wen1 = 2'b11; addr1 = 11'd9; wdata1 = 16'hFFFF; ren2 = 3'b111;
        for (int c = 0; c < 3; c++) addr2[c] = 11'd9;
        n = 0; seen = 0;
        while (n < 300) begin
            step(); n++;
            if (if_a.rvalid2 !== 3'b000 || if_b.rvalid2 !== 1'b0) seen++;
            if (if_a.busy !== 1'b1) break;
        end
        idle();
        total++; if (n !== 128) begin bad++; $display("FAIL clear_len: got %0d want 128", n); end
        total++; if (seen !== 0) begin bad++; $display("FAIL clear_rvalid: got %0d want 0", seen); end
        total++; if (if_b.busy !== 1'b0) begin bad++; $display("FAIL clear_end_b: got %b want 0", if_b.busy); end
        for (int i = 0; i < 129; i++) begin
            addr1 = (i < 128) ? 11'(i) : 11'd0;
            step();
            if (i < 128) begin
                total++; if (if_b.rdata1 !== 16'h0000) begin bad++; $display("FAIL clear_word_b[%0d]: got %h want 0000", i, if_b.rdata1); end
            end
            if (i > 0) begin
                total++; if (if_a.rdata1 !== 16'h0000) begin bad++; $display("FAIL clear_word_a[%0d]: got %h want 0000", i - 1, if_a.rdata1); end
            end
        end
    endtask

    task automatic test_byte_mask();
        wen1 = 2'b11; addr1 = 11'd5; wdata1 = 16'hA5C3; step();
        wen1 = 2'b10; wdata1 = 16'h1200; step();
        wen1 = 2'b00; wdata1 = 16'h0000; ren2 = 3'b001; addr2[0] = 11'd5; step();
        total++; if ({if_b.rdata1, if_b.rdata2, if_b.rvalid2} !== {16'h12C3, 16'h12C3, 1'b1}) begin
            bad++; $display("FAIL mask_b: got %h want %h", {if_b.rdata1, if_b.rdata2, if_b.rvalid2}, {16'h12C3, 16'h12C3, 1'b1}); end
        idle(); step();
        total++; if ({if_a.rdata1, if_a.rdata2[15:0], if_a.rvalid2} !== {16'h12C3, 16'h12C3, 3'b001}) begin
            bad++; $display("FAIL mask_a: got %h want %h", {if_a.rdata1, if_a.rdata2[15:0], if_a.rvalid2}, {16'h12C3, 16'h12C3, 3'b001}); end
        step();
        total++; if (if_a.rvalid2 !== 3'b000) begin bad++; $display("FAIL mask_a_pulse: got %b want 000", if_a.rvalid2); end
    endtask

    task automatic test_collision();
        wen1 = 2'b11; addr1 = 11'd7; wdata1 = 16'hBEEF; ren2 = 3'b001; addr2[0] = 11'd7; step();
        total++; if ({if_b.rdata1, if_b.rdata2} !== {16'hBEEF, 16'hBEEF}) begin
            bad++; $display("FAIL coll_wt_b: got %h want BEEFBEEF", {if_b.rdata1, if_b.rdata2}); end
        idle(); step();
        total++; if ({if_a.rdata1, if_a.rdata2[15:0]} !== 32'h0) begin
            bad++; $display("FAIL coll_rf_a: got %h want 00000000", {if_a.rdata1, if_a.rdata2[15:0]}); end
        ren2 = 3'b001; addr2[0] = 11'd7; step();
        total++; if (if_b.rdata2 !== 16'hBEEF) begin bad++; $display("FAIL coll_store_b: got %h want BEEF", if_b.rdata2); end
        idle(); step();
        total++; if (if_a.rdata2[15:0] !== 16'hBEEF) begin bad++; $display("FAIL coll_store_a: got %h want BEEF", if_a.rdata2[15:0]); end
    endtask

    task automatic test_multi_channel();
        wen1 = 2'b11;
        for (int i = 1; i <= 3; i++) begin
            addr1 = 11'(i); wdata1 = 16'(i * 16'h1111); step();
        end
        idle(); ren2 = 3'b010; addr2[1] = 11'd3; step();
        idle(); step();
        total++; if ({if_a.rvalid2, if_a.rdata2[31:16]} !== {3'b010, 16'h3333}) begin
            bad++; $display("FAIL multi_pre: got %h want %h", {if_a.rvalid2, if_a.rdata2[31:16]}, {3'b010, 16'h3333}); end
        ren2 = 3'b101; addr2[0] = 11'd1; addr2[1] = 11'd2; addr2[2] = 11'd3; step();
        total++; if (if_a.rvalid2 !== 3'b000) begin bad++; $display("FAIL multi_early: got %b want 000", if_a.rvalid2); end
        total++; if ({if_b.rvalid2, if_b.rdata2} !== {1'b1, 16'h1111}) begin
            bad++; $display("FAIL multi_b: got %h want %h", {if_b.rvalid2, if_b.rdata2}, {1'b1, 16'h1111}); end
        idle(); step();
        total++; if ({if_a.rvalid2, if_a.rdata2} !== {3'b101, 16'h3333, 16'h3333, 16'h1111}) begin
            bad++; $display("FAIL multi_lat2: got %h want %h", {if_a.rvalid2, if_a.rdata2}, {3'b101, 16'h3333, 16'h3333, 16'h1111}); end
        step();
        total++; if (if_a.rvalid2 !== 3'b000) begin bad++; $display("FAIL multi_pulse: got %b want 000", if_a.rvalid2); end
    endtask

    task automatic test_out_of_range();
        wen1 = 2'b11; addr1 = 11'd200; wdata1 = 16'hFFFF; ren2 = 3'b001; addr2[0] = 11'd200; step();
        total++; if ({if_b.rdata1, if_b.rdata2, if_b.rvalid2} !== {32'h0, 1'b1}) begin
            bad++; $display("FAIL oor_b: got %h want %h", {if_b.rdata1, if_b.rdata2, if_b.rvalid2}, {32'h0, 1'b1}); end
        idle(); step();
        total++; if ({if_a.rdata1, if_a.rdata2[15:0], if_a.rvalid2} !== {32'h0, 3'b001}) begin
            bad++; $display("FAIL oor_a: got %h want %h", {if_a.rdata1, if_a.rdata2[15:0], if_a.rvalid2}, {32'h0, 3'b001}); end
        addr1 = 11'd72; ren2 = 3'b001; addr2[0] = 11'd72; step();
        total++; if ({if_b.rdata1, if_b.rdata2} !== 32'h0) begin
            bad++; $display("FAIL oor_alias: got %h want 00000000", {if_b.rdata1, if_b.rdata2}); end
        idle(); step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            wen1   = 2'($urandom_range(0, 3));
            addr1  = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 135)) : 11'($urandom_range(0, 15));
            wdata1 = 16'($urandom);
            ren2   = 3'($urandom_range(0, 7));
            for (int c = 0; c < 3; c++)
                addr2[c] = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(120, 140)) : 11'($urandom_range(0, 15));
            clear_req = (i < 250) && ($urandom_range(0, 149) == 0);
            step();
            total++; if ({if_a.busy, if_a.rvalid2, if_a.rdata2, if_a.rdata1} !== {eb[0], ev[0], e2[0][2], e2[0][1], e2[0][0], e1[0]}) begin
                bad++; $display("FAIL rand_a[%0d]: got %h want %h", i, {if_a.busy, if_a.rvalid2, if_a.rdata2, if_a.rdata1},
                                {eb[0], ev[0], e2[0][2], e2[0][1], e2[0][0], e1[0]}); end
            total++; if ({if_b.busy, if_b.rvalid2, if_b.rdata2, if_b.rdata1} !== {eb[1], ev[1][0], e2[1][0], e1[1]}) begin
                bad++; $display("FAIL rand_b[%0d]: got %h want %h", i, {if_b.busy, if_b.rvalid2, if_b.rdata2, if_b.rdata1},
                                {eb[1], ev[1][0], e2[1][0], e1[1]}); end
        end
        idle();
    endtask

    task automatic test_reset_mid_clear();
        int n;
        clear_req = 1'b1; step(); clear_req = 1'b0;
        repeat (39) step();
        resetn = 1'b0; step();
        total++; if ({if_a.busy, if_b.busy} !== 2'b10) begin bad++; $display("FAIL midrst_busy: got %b want 10", {if_a.busy, if_b.busy}); end
        total++; if (if_a.clr_state !== CLEAR) begin bad++; $display("FAIL midrst_state: got %0d want CLEAR", if_a.clr_state); end
        resetn = 1'b1;
        n = 0;
        while (n < 300) begin
            addr1 = 11'($urandom_range(0, 127));
            step(); n++;
            total++; if ({if_b.busy, if_b.rdata1} !== {eb[1], e1[1]}) begin
                bad++; $display("FAIL midrst_b[%0d]: got %h want %h", n, {if_b.busy, if_b.rdata1}, {eb[1], e1[1]}); end
            if (if_a.busy !== 1'b1) break;
        end
        total++; if (n !== 128) begin bad++; $display("FAIL midrst_len: got %0d want 128", n); end
        for (int i = 0; i < 129; i++) begin
            idle();
            if (i < 128) begin addr1 = 11'(i); ren2 = 3'b001; addr2[0] = 11'(127 - i); end
            step();
            total++; if ({if_a.rvalid2, if_a.rdata2[15:0], if_a.rdata1} !== {ev[0], e2[0][0], e1[0]}) begin
                bad++; $display("FAIL sweep_a[%0d]: got %h want %h", i, {if_a.rvalid2, if_a.rdata2[15:0], if_a.rdata1}, {ev[0], e2[0][0], e1[0]}); end
            total++; if ({if_b.rvalid2, if_b.rdata2, if_b.rdata1} !== {ev[1][0], e2[1][0], e1[1]}) begin
                bad++; $display("FAIL sweep_b[%0d]: got %h want %h", i, {if_b.rvalid2, if_b.rdata2, if_b.rdata1}, {ev[1][0], e2[1][0], e1[1]}); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            left_m[k] = 0;
            for (int a = 0; a < 128; a++) mm[k][a] = 16'h0000;
        end
        resetn = 1'b0;
        idle();
        test_reset();
        test_clear();
        test_byte_mask();
        test_collision();
        test_multi_channel();
        test_out_of_range();
        test_random();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
